// File: rtl/game_session_ctrl.sv
// Per-session gameplay bookkeeping: gun move/shoot commands, shot cooldown, combo scoring, lives, high-score flag.
// All outputs registered (one cycle after the causing input); no backpressure, every input is sampled every cycle.
module game_session_ctrl #(
  parameter int SCORE_W       = 14,
  parameter int POINTS        = 10,
  parameter int LIVES_INIT    = 3,
  parameter int SHOT_COOLDOWN = 8,
  parameter int COMBO_MAX     = 4,
  parameter int COMBO_TIMEOUT = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [2:0]         game_state,
  input  logic [4:0]         buttons,
  input  logic [1:0]         plus_score,
  input  logic               player_hit,
  input  logic [SCORE_W-1:0] high_score,
  output logic [1:0]         move_gun,
  output logic               shoot,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic [2:0]         combo,
  output logic               new_high,
  output logic               over_req
);

  localparam int PW   = SCORE_W + 6;
  localparam int CD_W = (SHOT_COOLDOWN > 0) ? $clog2(SHOT_COOLDOWN + 1) : 1;
  localparam int TM_W = (COMBO_TIMEOUT > 1) ? $clog2(COMBO_TIMEOUT + 1) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [1:0]         move_gun_q, move_gun_d;
  logic               shoot_q, shoot_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic [2:0]         combo_q, combo_d;
  logic               new_high_q, new_high_d;
  logic               over_req_q, over_req_d;
  logic [CD_W-1:0]    cooldown_q, cooldown_d;
  logic [TM_W-1:0]    combo_tmr_q, combo_tmr_d;
  logic [2:0]         prev_state_q, prev_state_d;
  logic               btn_q, btn_d;

  logic          run;
  logic          restart;
  logic [PW-1:0] sum;

  always_comb begin
    move_gun_d   = 2'b00;
    shoot_d      = 1'b0;
    score_d      = score_q;
    lives_d      = lives_q;
    combo_d      = combo_q;
    new_high_d   = new_high_q;
    over_req_d   = 1'b0;
    cooldown_d   = cooldown_q;
    combo_tmr_d  = combo_tmr_q;
    prev_state_d = game_state;
    btn_d        = buttons[0];

    run     = (game_state == 3'd1);
    restart = (prev_state_q != 3'd1 && prev_state_q != 3'd2 && run) ||
              (prev_state_q == 3'd3 && game_state != 3'd3);
    sum     = {6'b0, score_q} + PW'(plus_score) * PW'(POINTS) * PW'(combo_q);

    if (restart) begin
      score_d     = '0;
      lives_d     = 4'(LIVES_INIT);
      combo_d     = 3'd1;
      new_high_d  = 1'b0;
      cooldown_d  = '0;
      combo_tmr_d = '0;
    end else begin
      if (score_q > high_score) new_high_d = 1'b1;

      // Everything below is frozen outside RUN, including both timers.
      if (run) begin
        if (buttons[2])      move_gun_d = 2'b01;
        else if (buttons[4]) move_gun_d = 2'b10;

        // Edges arriving during cooldown are dropped, never queued.
        if (buttons[0] && !btn_q && cooldown_q == '0) begin
          shoot_d    = 1'b1;
          cooldown_d = CD_W'(SHOT_COOLDOWN);
        end else if (frame_tick && cooldown_q != '0) begin
          cooldown_d = cooldown_q - 1'b1;
        end

        if (plus_score != 2'd0) begin
          if (sum > PW'(SCORE_MAX)) score_d = SCORE_MAX;
          else                      score_d = sum[SCORE_W-1:0];
        end

        if (player_hit) begin
          combo_d     = 3'd1;
          combo_tmr_d = '0;
        end else if (plus_score != 2'd0) begin
          combo_d     = (combo_q >= 3'(COMBO_MAX)) ? 3'(COMBO_MAX) : combo_q + 3'd1;
          combo_tmr_d = '0;
        end else if (frame_tick) begin
          if (combo_tmr_q == TM_W'(COMBO_TIMEOUT - 1)) begin
            combo_d     = 3'd1;
            combo_tmr_d = '0;
          end else begin
            combo_tmr_d = combo_tmr_q + 1'b1;
          end
        end

        if (player_hit && lives_q != 4'd0) begin
          lives_d    = lives_q - 4'd1;
          over_req_d = (lives_q == 4'd1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_gun_q   <= 2'b00;
      shoot_q      <= 1'b0;
      score_q      <= '0;
      lives_q      <= 4'(LIVES_INIT);
      combo_q      <= 3'd1;
      new_high_q   <= 1'b0;
      over_req_q   <= 1'b0;
      cooldown_q   <= '0;
      combo_tmr_q  <= '0;
      prev_state_q <= 3'd0;
      btn_q        <= 1'b0;
    end else begin
      move_gun_q   <= move_gun_d;
      shoot_q      <= shoot_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      combo_q      <= combo_d;
      new_high_q   <= new_high_d;
      over_req_q   <= over_req_d;
      cooldown_q   <= cooldown_d;
      combo_tmr_q  <= combo_tmr_d;
      prev_state_q <= prev_state_d;
      btn_q        <= btn_d;
    end
  end

  assign move_gun = move_gun_q;
  assign shoot    = shoot_q;
  assign score    = score_q;
  assign lives    = lives_q;
  assign combo    = combo_q;
  assign new_high = new_high_q;
  assign over_req = over_req_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Scoreboard bench for game_session_ctrl: a default instance plus an 8-bit-score instance for saturation.
module tb_game_session_ctrl;

  localparam int F_MOVE = 0, F_SHOOT = 1, F_SCORE = 2, F_LIVES = 3,
                 F_COMBO = 4, F_NEWH = 5, F_OVER = 6, F_SCORE_S = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [2:0]  game_state = 3'd0;
  logic [4:0]  buttons = 5'd0;
  logic [1:0]  plus_score = 2'd0;
  logic        player_hit = 1'b0;
  logic [13:0] high_score = 14'h3fff;
  logic [7:0]  high_score_s = 8'hff;

  logic [1:0]  move_gun, move_gun_s;
  logic        shoot, shoot_s;
  logic [13:0] score;
  logic [7:0]  score_s;
  logic [3:0]  lives, lives_s;
  logic [2:0]  combo, combo_s;
  logic        new_high, new_high_s;
  logic        over_req, over_req_s;

  game_session_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_state(game_state),
    .buttons(buttons), .plus_score(plus_score), .player_hit(player_hit),
    .high_score(high_score), .move_gun(move_gun), .shoot(shoot), .score(score),
    .lives(lives), .combo(combo), .new_high(new_high), .over_req(over_req)
  );

  game_session_ctrl #(.SCORE_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_state(game_state),
    .buttons(buttons), .plus_score(plus_score), .player_hit(player_hit),
    .high_score(high_score_s), .move_gun(move_gun_s), .shoot(shoot_s), .score(score_s),
    .lives(lives_s), .combo(combo_s), .new_high(new_high_s), .over_req(over_req_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string tag;
    int    fld;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int field(input int f);
    case (f)
      F_MOVE:  return int'(move_gun);
      F_SHOOT: return int'(shoot);
      F_SCORE: return int'(score);
      F_LIVES: return int'(lives);
      F_COMBO: return int'(combo);
      F_NEWH:  return int'(new_high);
      F_OVER:  return int'(over_req);
      default: return int'(score_s);
    endcase
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, field(e.fld), e.val);
    end
  end

  task automatic drv(input logic [2:0] gs, input logic [4:0] b, input logic [1:0] p,
                     input logic h, input logic f);
    game_state = gs; buttons = b; plus_score = p; player_hit = h; frame_tick = f;
  endtask

  task automatic ex(input string t, input int f, input int v);
    exp_t e;
    e.cyc = cyc_cnt + 1; e.tag = t; e.fld = f; e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_move", move_gun, 0);
    chk("rst_shoot", shoot, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_combo", combo, 1);
    chk("rst_newh", new_high, 0);
    chk("rst_over", over_req, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // Session start and gun movement
    drv(1, 5'b00000, 0, 0, 0); ex("start_score", F_SCORE, 0); ex("start_lives", F_LIVES, 3); tick();
    drv(1, 5'b00100, 0, 0, 0); ex("move_right", F_MOVE, 1); tick();
    drv(1, 5'b10100, 0, 0, 0); ex("move_both", F_MOVE, 1); tick();
    drv(1, 5'b10000, 0, 0, 0); ex("move_left", F_MOVE, 2); tick();
    drv(2, 5'b00100, 0, 0, 0); ex("move_pause", F_MOVE, 0); tick();
    drv(1, 5'b00000, 0, 0, 0); ex("move_idle", F_MOVE, 0); tick();

    // Holding shoot through 20 frames fires exactly once
    buttons = 5'b00001;
    for (int i = 0; i < 40; i++) begin
      frame_tick = (i % 2 == 1);
      ex("hold_shoot", F_SHOOT, (i == 0) ? 1 : 0);
      tick();
    end
    drv(1, 5'b00000, 0, 0, 0); ex("rel_shoot", F_SHOOT, 0); tick();
    drv(1, 5'b00001, 0, 0, 0); ex("repress_shoot", F_SHOOT, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drv(1, 5'b00000, 0, 0, 1); ex("cd3_shoot", F_SHOOT, 0); tick();
    end
    drv(1, 5'b00001, 0, 0, 0); ex("dropped_shoot", F_SHOOT, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drv(1, 5'b00000, 0, 0, 1); ex("cd8_shoot", F_SHOOT, 0); tick();
    end
    drv(1, 5'b00001, 0, 0, 0); ex("accepted_shoot", F_SHOOT, 1); tick();
    drv(1, 5'b00000, 0, 0, 0); ex("after_shoot", F_SHOOT, 0); tick();

    // Combo ramp on four consecutive kill frames, new_high against 50
    high_score = 14'd50;
    begin
      int exp_sc[4] = '{10, 30, 60, 100};
      int exp_cb[4] = '{2, 3, 4, 4};
      int exp_nh[4] = '{0, 0, 0, 1};
      for (int i = 0; i < 4; i++) begin
        drv(1, 5'b00000, 1, 0, 1);
        ex("kill_score", F_SCORE, exp_sc[i]);
        ex("kill_combo", F_COMBO, exp_cb[i]);
        ex("kill_newh", F_NEWH, exp_nh[i]);
        tick();
      end
    end
    for (int k = 1; k <= 60; k++) begin
      drv(1, 5'b00000, 0, 0, 1);
      ex("timeout_combo", F_COMBO, (k < 60) ? 4 : 1);
      tick();
    end
    high_score = 14'h3fff;
    drv(1, 5'b00000, 0, 0, 0); ex("sticky_newh", F_NEWH, 1); ex("idle_score", F_SCORE, 100); tick();

    // Combined kill+hit, then saturation on the 8-bit instance
    drv(1, 5'b00000, 3, 0, 0); ex("sat_a", F_SCORE, 130); ex("sat_a_cb", F_COMBO, 2); tick();
    drv(1, 5'b00000, 3, 1, 0); ex("killhit_score", F_SCORE, 190); ex("killhit_combo", F_COMBO, 1);
    ex("killhit_lives", F_LIVES, 2); ex("killhit_over", F_OVER, 0); tick();
    drv(1, 5'b00000, 1, 0, 0); ex("sat_b", F_SCORE, 200); tick();
    drv(1, 5'b00000, 1, 0, 0); ex("sat_c", F_SCORE, 220); tick();
    drv(1, 5'b00000, 1, 0, 0); ex("sat_d", F_SCORE_S, 250); ex("sat_d_cb", F_COMBO, 4); tick();
    drv(1, 5'b00000, 3, 0, 0); ex("sat_clamp", F_SCORE_S, 255); ex("wide_score", F_SCORE, 370); tick();
    drv(1, 5'b00000, 1, 0, 0); ex("sat_hold", F_SCORE_S, 255); ex("wide_score2", F_SCORE, 410); tick();

    // Pause freezes score, lives and combo
    drv(2, 5'b00000, 3, 1, 1); ex("pause_score", F_SCORE, 410); ex("pause_lives", F_LIVES, 2);
    ex("pause_combo", F_COMBO, 4); tick();
    drv(1, 5'b00000, 0, 0, 0); ex("resume_score", F_SCORE, 410); tick();

    // Lives run out with a single over_req
    drv(1, 5'b00000, 0, 1, 0); ex("hit2_lives", F_LIVES, 1); ex("hit2_over", F_OVER, 0); tick();
    drv(1, 5'b00000, 0, 0, 0); ex("gap_over", F_OVER, 0); tick();
    drv(1, 5'b00000, 0, 1, 0); ex("hit3_lives", F_LIVES, 0); ex("hit3_over", F_OVER, 1); tick();
    drv(1, 5'b00000, 0, 0, 0); ex("over_pulse", F_OVER, 0); tick();
    drv(1, 5'b00000, 0, 1, 0); ex("hit4_lives", F_LIVES, 0); ex("hit4_over", F_OVER, 0); tick();

    // Game over -> start screen -> run restarts the session
    drv(3, 5'b00000, 0, 0, 0); ex("over_score", F_SCORE, 410); tick();
    drv(0, 5'b00000, 0, 0, 0); ex("leave_score", F_SCORE, 0); ex("leave_lives", F_LIVES, 3);
    ex("leave_combo", F_COMBO, 1); ex("leave_newh", F_NEWH, 0); ex("leave_score_s", F_SCORE_S, 0); tick();
    drv(1, 5'b00000, 0, 0, 0); ex("restart_score", F_SCORE, 0); ex("restart_lives", F_LIVES, 3); tick();

    // Asynchronous reset in the middle of a session
    drv(1, 5'b00100, 1, 1, 0); ex("pre_rst_score", F_SCORE, 10); ex("pre_rst_lives", F_LIVES, 2); tick();
    drv(1, 5'b00100, 0, 0, 0); ex("pre_rst_move", F_MOVE, 1); tick();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_score", score, 0);
    chk("arst_lives", lives, 3);
    chk("arst_combo", combo, 1);
    chk("arst_move", move_gun, 0);
    chk("arst_over", over_req, 0);
    drv(0, 5'b00000, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within budget");
    $fatal(1);
  end

endmodule
